// File: rtl/calc_pkg.sv
// Shared definitions for the calculator memory-key controller:
// key codes, FSM state encoding and default widths.
package calc_pkg;

    // Default width of stored, displayed and recalled values
    localparam int DEFAULT_DATA_WIDTH = 16;

    // Decoded pushbutton codes
    localparam logic [1:0] KEY_BACKSPACE = 2'b00;
    localparam logic [1:0] KEY_MS        = 2'b01;
    localparam logic [1:0] KEY_MR        = 2'b10;
    localparam logic [1:0] KEY_MC        = 2'b11;

    // Controller FSM states
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        DEBOUNCE = 2'b01,
        EXECUTE  = 2'b10,
        HOLD     = 2'b11
    } state_t;

    // Width needed for a counter that must be able to hold the value 'cycles'
    function automatic int debounceCountWidth(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/memory_key_controller_if.sv
// Key, display and recall-handshake signals of the memory-key controller.
// The master side drives the keypad/datapath inputs, the slave is the controller.
interface memory_key_controller_if #(
    parameter int DATA_WIDTH = calc_pkg::DEFAULT_DATA_WIDTH
);

    logic [1:0]            pushbuttons;
    logic                  pushButtonPressed;
    logic [DATA_WIDTH-1:0] display_value;
    logic                  recall_ready;
    logic                  recall_valid;
    logic [DATA_WIDTH-1:0] recall_data;
    logic                  backspace;
    logic                  mem_full;
    logic                  busy;

    modport master (
        output pushbuttons,
        output pushButtonPressed,
        output display_value,
        output recall_ready,
        input  recall_valid,
        input  recall_data,
        input  backspace,
        input  mem_full,
        input  busy
    );

    modport slave (
        input  pushbuttons,
        input  pushButtonPressed,
        input  display_value,
        input  recall_ready,
        output recall_valid,
        output recall_data,
        output backspace,
        output mem_full,
        output busy
    );

endinterface

// File: rtl/key_debouncer.sv
// Press/release qualification for the memory-key controller.
// One saturating counter is shared by both phases: in press mode it counts
// cycles where the held code still matches the captured one, in release mode
// it counts cycles with no key held. Any non-qualifying sample restarts it.
module key_debouncer
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       i_clear,
    input  logic       i_release_mode,
    input  logic       i_pressed,
    input  logic [1:0] i_code,
    input  logic [1:0] i_captured_code,
    output logic       o_stable,
    output logic       o_released
);

    localparam int             COUNT_WIDTH = debounceCountWidth(DEBOUNCE_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = COUNT_WIDTH'(DEBOUNCE_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [COUNT_WIDTH-1:0] r_count;
    logic                   w_match;
    logic                   w_done;

    // A sample qualifies when the key is still held with the same code (press)
    // or when nothing is held (release)
    assign w_match = i_release_mode ? !i_pressed
                                    : (i_pressed && (i_code == i_captured_code));

    // The current sample completes the run when it is the last one needed
    assign w_done = w_match && (r_count >= COUNT_LAST);

    // Count consecutive qualifying samples, restarting on clear or a bad sample, saturating at the top
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear || !w_match) begin
            r_count <= '0;
        end else if (r_count != COUNT_MAX) begin
            r_count <= r_count + COUNT_WIDTH'(1);
        end
    end

    assign o_stable   = w_done && !i_release_mode;
    assign o_released = w_done && i_release_mode;

endmodule

// File: rtl/memory_key_controller.sv
// Calculator memory-key controller: qualifies a single key press, executes
// backspace / MS / MR / MC exactly once per press, holds the memory register
// and offers recalled values over a valid/ready handshake.
module memory_key_controller
    import calc_pkg::*;
#(
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                    clock,
    input  logic                    reset_n,
    memory_key_controller_if.slave  bus
);

    state_t                r_state;
    state_t                w_next_state;
    logic [1:0]            r_code;
    logic [DATA_WIDTH-1:0] r_memory;
    logic                  r_mem_full;

    logic                  w_capture;
    logic                  w_clear;
    logic                  w_release_mode;
    logic                  w_stable;
    logic                  w_released;
    logic                  w_recall_valid;
    logic                  w_backspace;
    logic                  w_execute_ms;
    logic                  w_execute_mc;

    // The counter runs in release mode only while waiting for the key to be let go
    assign w_release_mode = (r_state == HOLD);

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debouncer (
        .clock           (clock),
        .reset_n         (reset_n),
        .i_clear         (w_clear),
        .i_release_mode  (w_release_mode),
        .i_pressed       (bus.pushButtonPressed),
        .i_code          (bus.pushbuttons),
        .i_captured_code (r_code),
        .o_stable        (w_stable),
        .o_released      (w_released)
    );

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and Moore output decode; the counter is held clear in IDLE and EXECUTE
    always_comb begin
        w_next_state   = r_state;
        w_capture      = 1'b0;
        w_clear        = 1'b0;
        w_recall_valid = 1'b0;
        w_backspace    = 1'b0;
        case (r_state)
            IDLE: begin
                w_clear = 1'b1;
                if (bus.pushButtonPressed) begin
                    w_capture    = 1'b1;
                    w_next_state = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!bus.pushButtonPressed || (bus.pushbuttons != r_code)) begin
                    w_next_state = IDLE;
                end else if (w_stable) begin
                    w_next_state = EXECUTE;
                end
            end
            EXECUTE: begin
                w_clear = 1'b1;
                case (r_code)
                    KEY_MR: begin
                        w_recall_valid = 1'b1;
                        if (bus.recall_ready) begin
                            w_next_state = HOLD;
                        end
                    end
                    KEY_BACKSPACE: begin
                        w_backspace  = 1'b1;
                        w_next_state = HOLD;
                    end
                    default: begin
                        w_next_state = HOLD;
                    end
                endcase
            end
            HOLD: begin
                if (w_released) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Latch the key code on the edge that starts qualification
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_code <= KEY_BACKSPACE;
        end else if (w_capture) begin
            r_code <= bus.pushbuttons;
        end
    end

    assign w_execute_ms = (r_state == EXECUTE) && (r_code == KEY_MS);
    assign w_execute_mc = (r_state == EXECUTE) && (r_code == KEY_MC);

    // Memory register and "M" indicator: MS stores the display, MC clears, MR leaves them alone
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_memory   <= '0;
            r_mem_full <= 1'b0;
        end else if (w_execute_ms) begin
            r_memory   <= bus.display_value;
            r_mem_full <= 1'b1;
        end else if (w_execute_mc) begin
            r_memory   <= '0;
            r_mem_full <= 1'b0;
        end
    end

    assign bus.recall_valid = w_recall_valid;
    assign bus.recall_data  = w_recall_valid ? r_memory : '0;
    assign bus.backspace    = w_backspace;
    assign bus.mem_full     = r_mem_full;
    assign bus.busy         = (r_state != IDLE);

endmodule

// File: tb/tb_memory_key_controller.sv
// Bench for memory_key_controller with DEBOUNCE_CYCLES=4, DATA_WIDTH=16.
// Backspace strobes and recall transfers are predicted into a scoreboard
// queue as keys are driven and matched when the controller produces them.
module tb_memory_key_controller;
    import calc_pkg::*;

    localparam int DW          = 16;
    localparam int DC          = 4;
    localparam int KIND_BS     = 1;
    localparam int KIND_RECALL = 2;

    typedef struct {
        int            kind;
        logic [DW-1:0] data;
    } expect_t;

    logic    clock   = 1'b0;
    logic    reset_n = 1'b0;
    int      totalChecks = 0;
    int      badChecks   = 0;
    expect_t expQ[$];

    memory_key_controller_if #(.DATA_WIDTH(DW)) bus ();

    memory_key_controller #(
        .DATA_WIDTH      (DW),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // Free-running 100 MHz clock
    always #5 clock = ~clock;

    // Count a comparison and report it when observed differs from expected
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive the keypad for a number of rising edges
    task automatic applyStimulus(input logic pressed, input logic [1:0] code, input int cycles);
        bus.pushButtonPressed = pressed;
        bus.pushbuttons       = code;
        repeat (cycles) tick();
    endtask

    // Predict one output event
    task automatic pushExpect(input int kind, input logic [DW-1:0] data);
        expect_t e;
        e.kind = kind;
        e.data = data;
        expQ.push_back(e);
    endtask

    // Let go of the key; busy must stay high until the fourth low sample
    task automatic releaseKey();
        bus.pushButtonPressed = 1'b0;
        for (int j = 1; j <= DC; j++) begin
            tick();
            checkOutput("release_busy", bus.busy, (j < DC));
        end
    endtask

    // Every output must be low while or right after reset is applied
    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, bus.busy, 0);
        checkOutput({tag, "_mem_full"}, bus.mem_full, 0);
        checkOutput({tag, "_recall_valid"}, bus.recall_valid, 0);
        checkOutput({tag, "_recall_data"}, bus.recall_data, 0);
        checkOutput({tag, "_backspace"}, bus.backspace, 0);
    endtask

    // Monitor: match each backspace strobe and each completed recall against the scoreboard
    always @(negedge clock) begin : monitor
        expect_t e;
        if (reset_n) begin
            if (bus.backspace) begin
                checkOutput("sb_pending_bs", (expQ.size() > 0), 1);
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checkOutput("sb_kind_bs", KIND_BS, e.kind);
                end
            end
            if (bus.recall_valid && bus.recall_ready) begin
                checkOutput("sb_pending_recall", (expQ.size() > 0), 1);
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checkOutput("sb_kind_recall", KIND_RECALL, e.kind);
                    checkOutput("sb_recall_data", bus.recall_data, e.data);
                end
            end
        end
    end

    // Guard against a stuck run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence
    initial begin
        bus.pushbuttons       = KEY_BACKSPACE;
        bus.pushButtonPressed = 1'b0;
        bus.display_value     = '0;
        bus.recall_ready      = 1'b0;
        reset_n               = 1'b0;
        repeat (3) tick();
        checkResetOutputs("reset");
        reset_n = 1'b1;
        tick();
        checkOutput("idle_busy", bus.busy, 0);

        $display("[TB] MS with long hold");
        bus.display_value     = 16'h0123;
        bus.pushbuttons       = KEY_MS;
        bus.pushButtonPressed = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checkOutput("ms_busy", bus.busy, 1);
            checkOutput("ms_full", bus.mem_full, (k >= 6));
            if (k == 6) bus.display_value = 16'hBEEF;
        end
        releaseKey();

        $display("[TB] MR with delayed ready");
        pushExpect(KIND_RECALL, 16'h0123);
        bus.recall_ready = 1'b0;
        applyStimulus(1'b1, KEY_MR, 4);
        checkOutput("mr_early_valid", bus.recall_valid, 0);
        tick();
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) bus.recall_ready = 1'b1;
            checkOutput("mr_valid", bus.recall_valid, 1);
            checkOutput("mr_data", bus.recall_data, 16'h0123);
            tick();
        end
        checkOutput("mr_done_valid", bus.recall_valid, 0);
        checkOutput("mr_full", bus.mem_full, 1);
        bus.recall_ready = 1'b0;
        releaseKey();

        $display("[TB] backspace glitch and real press");
        applyStimulus(1'b1, KEY_BACKSPACE, 2);
        checkOutput("glitch_busy", bus.busy, 1);
        applyStimulus(1'b0, KEY_BACKSPACE, 1);
        checkOutput("glitch_idle", bus.busy, 0);
        repeat (3) tick();
        pushExpect(KIND_BS, '0);
        bus.pushButtonPressed = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checkOutput("bs_strobe", bus.backspace, (k == 5));
        end
        releaseKey();

        $display("[TB] MC then MR of empty memory");
        applyStimulus(1'b1, KEY_MC, 6);
        checkOutput("mc_full", bus.mem_full, 0);
        releaseKey();
        pushExpect(KIND_RECALL, 16'h0000);
        bus.recall_ready = 1'b1;
        applyStimulus(1'b1, KEY_MR, 5);
        checkOutput("mr_fast_valid", bus.recall_valid, 1);
        checkOutput("mr_fast_data", bus.recall_data, 16'h0000);
        tick();
        checkOutput("mr_fast_done", bus.recall_valid, 0);
        checkOutput("mr_fast_busy", bus.busy, 1);
        bus.recall_ready = 1'b0;
        releaseKey();

        $display("[TB] reset during recall, key held across release");
        bus.display_value = 16'h5A5A;
        applyStimulus(1'b1, KEY_MS, 6);
        releaseKey();
        applyStimulus(1'b1, KEY_MR, 5);
        checkOutput("pre_rst_valid", bus.recall_valid, 1);
        checkOutput("pre_rst_data", bus.recall_data, 16'h5A5A);
        reset_n = 1'b0;
        #1;
        checkResetOutputs("rst_mid");
        tick();
        tick();
        reset_n = 1'b1;
        pushExpect(KIND_RECALL, 16'h0000);
        bus.recall_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checkOutput("post_rst_valid", bus.recall_valid, (k == 5));
        end
        tick();
        checkOutput("post_rst_done", bus.recall_valid, 0);
        bus.recall_ready = 1'b0;
        releaseKey();
        checkOutput("post_rst_full", bus.mem_full, 0);

        $display("[TB] code switch during debounce, release bounce");
        bus.display_value = 16'h7777;
        applyStimulus(1'b1, KEY_MS, 6);
        releaseKey();
        bus.display_value = 16'h1111;
        applyStimulus(1'b1, KEY_MS, 2);
        applyStimulus(1'b1, KEY_MC, 1);
        checkOutput("switch_idle", bus.busy, 0);
        applyStimulus(1'b0, KEY_MC, 1);
        checkOutput("switch_busy", bus.busy, 0);
        checkOutput("switch_full", bus.mem_full, 1);
        pushExpect(KIND_RECALL, 16'h7777);
        bus.recall_ready = 1'b1;
        applyStimulus(1'b1, KEY_MR, 6);
        bus.recall_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.pushButtonPressed = (i == 1);
            tick();
            checkOutput("bounce_busy", bus.busy, (i < 5));
        end

        repeat (3) tick();
        checkOutput("sb_empty", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
